// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter and frame timer.
// Frame geometry and arbiter state encoding.
package uart_tx_arbiter_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic int frame_cyc(
    input int clk_div,
    input int frame_bits,
    input int gap_cyc
  );
    return clk_div * frame_bits + gap_cyc;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Load / count-down / done timer that spans one UART frame plus gap.
// Loaded with FRAME_CYC-1 so a count from load to done covers FRAME_CYC cycles.
module uart_frame_timer #(
  parameter int FRAME_CYC = 42
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(FRAME_CYC + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(FRAME_CYC - 1);

  logic [W-1:0] cnt;

  // count register: load wins, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between two requesters.
// uart_tx has no busy output, so each frame is timed locally.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FRAME_BITS = UART_FRAME_BITS,
  parameter int GAP_CYC    = 2
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       owner_b
);

  localparam int FRAME_CYC = frame_cyc(CLK_DIV, FRAME_BITS, GAP_CYC);

  state_t state;
  state_t state_n;

  logic lock;
  logic rr_next;
  logic grant_b;
  logic accept;
  logic acc_last;
  logic [7:0] acc_data;
  logic t_load;
  logic t_en;
  logic t_done;

  uart_frame_timer #(
    .FRAME_CYC(FRAME_CYC)
  ) u_timer (
    .clk (sclk),
    .rst (s_rst),
    .load(t_load),
    .en  (t_en),
    .done(t_done)
  );

  // grant: locked owner first, then a lone requester, then round-robin
  always_comb begin
    grant_b = rr_next;
    if (lock) begin
      grant_b = owner_b;
    end else if (a_valid ^ b_valid) begin
      grant_b = b_valid;
    end
  end

  assign a_ready  = (state == ST_IDLE) && !grant_b && a_valid;
  assign b_ready  = (state == ST_IDLE) && grant_b && b_valid;
  assign accept   = a_ready || b_ready;
  assign acc_data = grant_b ? b_data : a_data;
  assign acc_last = grant_b ? b_last : a_last;

  assign tx_trig = (state == ST_TRIG);
  assign busy    = (state != ST_IDLE);

  // state register
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state and timer control
  always_comb begin
    state_n = state;
    t_load  = 1'b0;
    t_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_n = ST_TRIG;
      end
      ST_TRIG: begin
        t_load  = 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        t_en = 1'b1;
        if (t_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // accepted byte, owner, packet lock and round-robin pointer
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      tx_data <= 8'h00;
      owner_b <= 1'b0;
      lock    <= 1'b0;
      rr_next <= 1'b0;
    end else if (accept) begin
      tx_data <= acc_data;
      owner_b <= grant_b;
      lock    <= !acc_last;
      if (acc_last) rr_next <= !grant_b;
    end
  end

endmodule
